// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: default widths, reset PC,
// the NOP encoding and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam logic [7:0]  DEF_RESET_PC = 8'h00;

  // All-zero word decodes as a no-operation.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Fetch sequencer states.
  //   ISSUE   : may send a request this cycle
  //   WAIT    : one request in flight, its response will be queued
  //   DISCARD : one request in flight, its response belongs to a flushed path
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} pairs between the fetch sequencer and
// decode. Head outputs come straight from storage, so they hold steady until
// the entry is popped. flush empties the queue and wins over push.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       QDEPTH   = 2,
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       CNT_W    = $clog2(QDEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [CNT_W-1:0]   count,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic               empty
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [ADDR_W-1:0]  pc_mem    [QDEPTH];
  logic [INSTR_W-1:0] instr_mem [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(QDEPTH));

  // A pop only takes effect on a non-empty queue; a push into a full queue is
  // accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (QDEPTH is 2^n).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is reset as well so that the head reads as
      // {RESET_PC, NOP} straight out of reset instead of X.
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem[i]    <= RESET_PC;
        instr_mem[i] <= INSTR_W'(NOP_INSTR);
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples pre-edge values.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory, buffers responses in a prefetch queue and hands
// {instruction, pc} to decode over valid/ready. Execute redirects flush all
// in-flight work; a response already in flight is dropped via DISCARD.
// Optional build macro FETCH_PERF_CNT_EN adds saturating bubble/redirect
// counters on two extra output ports.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  current_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        redirect_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_e       state;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               outstanding;
  logic [OCC_W-1:0]   occupancy;
  logic               issue;
  logic               q_push;
  logic               q_pop;
  logic [CNT_W-1:0]   q_count;
  logic               q_empty;

  // Every non-ISSUE state has exactly one request in flight.
  assign outstanding = (state != ISSUE);

  // Slots already claimed: queued entries plus the response still to come.
  assign occupancy = {1'b0, q_count} + OCC_W'(outstanding);

  // Request only when a slot is guaranteed for the response, never in a
  // redirect cycle, and never while held in reset. This is combinational so a
  // freshly redirected PC reaches memory one cycle after the redirect.
  assign issue = reset && (state == ISSUE) && !redirect_valid &&
                 (occupancy < OCC_W'(QDEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // Only responses for the live path are queued; a response coinciding with a
  // redirect is dropped along with everything else.
  assign q_push = (state == WAIT) && imem_rvalid && !redirect_valid;

  // A handshake in a redirect cycle is still a consumed instruction; the
  // flush below clears whatever is left.
  assign q_pop = out_valid && out_ready;

  // Fetch sequencer: PC update, request bookkeeping and redirect handling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ISSUE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      // A response landing in this very cycle retires the outstanding
      // request, so there is nothing left to discard.
      state    <= (outstanding && !imem_rvalid) ? DISCARD : ISSUE;
    end else begin
      case (state)
        ISSUE: begin
          if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) state <= ISSUE;
        end
        DISCARD: begin
          if (imem_rvalid) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH   (QDEPTH),
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) u_fetch_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .push_pc    (req_pc),
    .push_instr (imem_rdata),
    .count      (q_count),
    .head_pc    (current_pc),
    .head_instr (instruction),
    .empty      (q_empty)
  );

  assign out_valid = !q_empty;

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: decode-starved cycles and redirect cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!out_valid && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
      if (redirect_valid && (redirect_cnt != 16'hFFFF)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A memory model answers each
// request after a programmable latency with mem[a] = 16'hA000 + a. A
// scoreboard holds the instruction stream decode should see (consecutive PCs
// from the reset PC or the latest redirect target); a monitor pops it on
// every handshake and compares.
module tb_instr_fetch_unit;

  localparam logic [7:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instruction;
  logic [7:0]  current_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] redirect_cnt;
`endif

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction    (instruction),
    .current_pc     (current_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .bubble_cnt     (bubble_cnt),
    .redirect_cnt   (redirect_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int handshakes = 0;

  exp_t       exp_q[$];
  logic [7:0] model_pc;

  // Memory model state (one request at a time).
  bit         pend_valid = 1'b0;
  logic [7:0] pend_addr  = '0;
  int         pend_delay = 0;
  int         lat        = 1;
  int         req_count  = 0;
  logic [7:0] req_log[$];

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'hA000 + {8'h00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, driven on the falling edge. The memory
  // response for this cycle is decided first so a redirect can be aligned
  // with it when redir_on_rv is set.
  task automatic step(input bit redir, input logic [7:0] tgt, input bit rdy,
                      input bit redir_on_rv, output bit fired);
    @(negedge clk);
    if (pend_valid && pend_delay == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
      pend_valid  = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      if (pend_valid) pend_delay--;
    end
    fired = redir_on_rv ? (imem_rvalid && out_valid) : redir;
    redirect_valid = fired;
    redirect_pc    = tgt;
    out_ready      = (redir_on_rv && fired) ? 1'b1 : rdy;
    #1;
    if (fired) check("no_req_in_redirect_cycle", imem_req, 1'b0);
    if (imem_req) begin
      check("single_outstanding", pend_valid, 1'b0);
      pend_valid = 1'b1;
      pend_addr  = imem_addr;
      pend_delay = lat - 1;
      req_count++;
      req_log.push_back(imem_addr);
    end
  endtask

  task automatic tick(input bit redir, input logic [7:0] tgt, input bit rdy);
    bit f;
    step(redir, tgt, rdy, 1'b0, f);
  endtask

  // Monitor / scoreboard: samples mid low-phase, after the driver settles.
  initial begin : monitor
    exp_t        e;
    bit          prev_hold;
    bit          prev_redir;
    logic [7:0]  prev_pc;
    logic [15:0] prev_instr;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    model_pc   = RESET_PC;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        exp_q.delete();
        model_pc   = RESET_PC;
        prev_hold  = 1'b0;
        prev_redir = 1'b0;
      end else begin
        if (prev_redir) check("out_valid_after_redirect", out_valid, 1'b0);
        if (prev_hold) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_pc", current_pc, prev_pc);
          check("hold_instr", instruction, prev_instr);
        end
        if (out_valid && out_ready) begin
          while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc++;
          end
          e = exp_q.pop_front();
          check("out_pc", current_pc, e.pc);
          check("out_instr", instruction, e.instr);
          handshakes++;
        end
        if (redirect_valid) begin
          exp_q.delete();
          model_pc = redirect_pc;
          while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            model_pc++;
          end
        end
        prev_hold  = out_valid && !out_ready && !redirect_valid;
        prev_redir = redirect_valid;
        prev_pc    = current_pc;
        prev_instr = instruction;
      end
    end
  end

  initial begin : driver
    bit  f;
    bit  found;
    int  rc0, rc1, rc2, hs0;

    reset          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_current_pc", current_pc, RESET_PC);
    check("rst_instruction", instruction, 16'h0000);
    #1;
    req_log.delete();
    reset = 1'b1;

    // Sequential fetch with 1-cycle memory, decode always ready.
    lat = 1;
    repeat (12) tick(1'b0, 8'h00, 1'b1);
    check("first_req_count_ok", (req_log.size() >= 3), 1'b1);
    if (req_log.size() >= 3) begin
      check("first_req_addr0", req_log[0], 8'h00);
      check("first_req_addr1", req_log[1], 8'h01);
      check("first_req_addr2", req_log[2], 8'h02);
    end

    // Decode stalls for 10 cycles: queue fills, requests stop.
    rc0 = req_count;
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    rc1 = req_count;
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    rc2 = req_count;
    check("stall_req_bound", ((rc2 - rc0) <= 2), 1'b1);
    check("stall_no_req_tail", rc2 - rc1, 0);
    check("stall_out_valid", out_valid, 1'b1);
    repeat (10) tick(1'b0, 8'h00, 1'b1);

    // Redirect to 8'h40 while the request for 8'h05 is in flight.
    lat = 2;
    tick(1'b1, 8'h05, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (pend_valid && pend_addr == 8'h05 && pend_delay >= 1) found = 1'b1;
    end
    check("discard_setup_found", found, 1'b1);
    tick(1'b1, 8'h40, 1'b1);
    repeat (14) tick(1'b0, 8'h00, 1'b1);

    // Minimum redirect-to-out_valid latency with nothing outstanding.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (!pend_valid) found = 1'b1;
    end
    check("idle_setup_found", found, 1'b1);
    tick(1'b1, 8'h20, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("redir_lat_c1", out_valid, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("redir_lat_c2", out_valid, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("redir_lat_c3", out_valid, 1'b1);
    check("redir_lat_pc", current_pc, 8'h20);
    check("redir_lat_instr", instruction, 16'hA020);
    repeat (6) tick(1'b0, 8'h00, 1'b1);

    // PC wrap-around from 8'hFE.
    hs0 = handshakes;
    tick(1'b1, 8'hFE, 1'b1);
    repeat (14) tick(1'b0, 8'h00, 1'b1);
    check("wrap_progress", ((handshakes - hs0) >= 4), 1'b1);

    // Redirect coinciding with a handshake and a memory response.
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step(1'b0, 8'h80, 1'($urandom_range(0, 1)), 1'b1, f);
      if (f) found = 1'b1;
    end
    check("same_cycle_opportunity", found, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check("same_cycle_valid_drop", out_valid, 1'b0);
    repeat (10) tick(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-WAIT with a non-empty queue.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (out_valid && pend_valid) found = 1'b1;
    end
    check("reset_setup_found", found, 1'b1);
    #2;
    reset          = 1'b0;
    pend_valid     = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_current_pc", current_pc, RESET_PC);
    check("async_rst_instruction", instruction, 16'h0000);
    check("async_rst_imem_req", imem_req, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    req_log.delete();
    reset = 1'b1;
    lat   = 1;
    repeat (10) tick(1'b0, 8'h00, 1'b1);
    check("restart_req_count_ok", (req_log.size() >= 2), 1'b1);
    if (req_log.size() >= 2) begin
      check("restart_addr0", req_log[0], RESET_PC);
      check("restart_addr1", req_log[1], RESET_PC + 8'h01);
    end

    // Randomised traffic: latency, back-pressure and redirects.
    hs0 = handshakes;
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] tgt;
      lat = $urandom_range(1, 3);
      tgt = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      tick(($urandom_range(0, 99) < 3), tgt, ($urandom_range(0, 99) < 70));
    end
    repeat (8) tick(1'b0, 8'h00, 1'b1);
    check("random_progress", ((handshakes - hs0) > 150), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
